// File: rtl/column_shift_loader_if.sv
// Bus between the stimulus source and the per-column serial loader:
// shift/preload/clear controls in, column image and window handshake out.
interface column_shift_loader_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned COLS  = 2 * N - 1;
  localparam int unsigned TOTAL = N * N;
  localparam int unsigned CW    = $clog2(N + 1);

  logic             clr;
  logic             en;
  logic             in_ready;
  logic [COLS-1:0]  ser_in;
  logic             par_load;
  logic [TOTAL-1:0] par_in;
  logic [TOTAL-1:0] cols_out;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    fill_cnt;

  modport slave (
    input  clr, en, ser_in, par_load, par_in, out_ready,
    output in_ready, cols_out, out_valid, fill_cnt
  );

  modport master (
    output clr, en, ser_in, par_load, par_in, out_ready,
    input  in_ready, cols_out, out_valid, fill_cnt
  );
endinterface

// File: rtl/column_shift_loader.sv
// Per-column serial loader with triangular column heights, preload, fill
// tracking and a sliding (MODE=0) or block (MODE=1) output window.
module column_shift_loader #(
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = 0
) (
  input logic                 clk,
  input logic                 rst,
  column_shift_loader_if.slave bus
);
  localparam int unsigned COLS  = 2 * N - 1;
  localparam int unsigned TOTAL = N * N;
  localparam int unsigned CW    = $clog2(N + 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  function automatic int unsigned col_h(input int unsigned c);
    return (c + 1 < COLS - c) ? c + 1 : COLS - c;
  endfunction

  function automatic int unsigned col_off(input int unsigned c);
    int unsigned o;
    o = 0;
    for (int unsigned k = 0; k < c; k++) o += col_h(k);
    return o;
  endfunction

  function automatic logic [TOTAL-1:0] base_mask();
    logic [TOTAL-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < COLS; c++) m[col_off(c)] = 1'b1;
    return m;
  endfunction

  function automatic logic [TOTAL-1:0] spread(input logic [COLS-1:0] s);
    logic [TOTAL-1:0] v;
    v = '0;
    for (int unsigned c = 0; c < COLS; c++) v[col_off(c)] = s[c];
    return v;
  endfunction

  localparam logic [TOTAL-1:0] BASE = base_mask();

  logic [TOTAL-1:0] data_q, data_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             valid;
  logic             in_rdy;
  logic             fire;
  logic             hs;
  logic [TOTAL-1:0] shifted;

  assign valid  = (fill_q == FULL);
  assign in_rdy = (MODE == 0) ? 1'b1 : (!valid || bus.out_ready);
  assign fire   = bus.en && in_rdy;
  assign hs     = (MODE != 0) && valid && bus.out_ready;

  // Columns are contiguous, so one left shift of the whole image moves every
  // column up by one; each column's bottom bit is then replaced by its serial
  // input, which also discards the bit spilled from the column below.
  assign shifted = ((data_q << 1) & ~BASE) | spread(bus.ser_in);

  always_comb begin
    data_d = data_q;
    fill_d = fill_q;
    if (bus.clr) begin
      data_d = '0;
      fill_d = '0;
    end else if (bus.par_load) begin
      data_d = bus.par_in;
      fill_d = FULL;
    end else begin
      if (fire) data_d = shifted;
      if (hs)                         fill_d = fire ? CW'(1) : '0;
      else if (fire && fill_q != FULL) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      fill_q <= '0;
    end else begin
      data_q <= data_d;
      fill_q <= fill_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.cols_out  = data_q;
  assign bus.out_valid = valid;
  assign bus.fill_cnt  = fill_q;
endmodule
